// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic matrix-multiply engine:
//   - default array geometry / operand / accumulator widths
//   - engine FSM state encoding
//   - width derivation helpers (k_len counter width, generic counter width)
// ----------------------------------------------------------------------------
package sa_pkg;

    localparam int DIM_DEF  = 4;
    localparam int DW_DEF   = 8;
    localparam int AW_DEF   = 20;
    localparam int KMAX_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } sa_state_e;

    // Width able to hold 0..kmax inclusive.
    function automatic int kw_of(input int kmax);
        return $clog2(kmax + 1);
    endfunction

    // Width able to index 0..n-1, never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// ----------------------------------------------------------------------------
// sa_pe
// One multiply-accumulate cell of the output-stationary array.
//   clk, rstn   clock, synchronous active-low reset
//   clr         synchronous accumulator clear (job start)
//   signed_en   1: operands are two's complement, 0: unsigned
//   a_in/b_in   {valid tag, operand} arriving from the left / from above
//   a_out/b_out the same words registered once, forwarded right / down
//   acc         running sum, wraps modulo 2^AW
// ----------------------------------------------------------------------------
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          signed_en,
    input  logic [DW:0]   a_in,
    input  logic [DW:0]   b_in,
    output logic [DW:0]   a_out,
    output logic [DW:0]   b_out,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] prod_s;

    // Widen an operand to the accumulator width; sign bit replicated only in signed mode.
    function automatic logic [AW-1:0] ext(input logic [DW-1:0] v, input logic sgn);
        return {{(AW-DW){sgn & v[DW-1]}}, v};
    endfunction

    // An AW-bit product of the widened operands is exact modulo 2^AW for both modes.
    assign prod_s = ext(a_in[DW-1:0], signed_en) * ext(b_in[DW-1:0], signed_en);

    // Forwarding registers: one stage per hop keeps A and B wavefronts aligned.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_out <= '0;
            b_out <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
        end
    end

    // Accumulator: bubbles (either tag low) leave the sum untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (a_in[DW] && b_in[DW]) begin
            acc <= acc + prod_s;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/sa_matmul_engine.sv
// ----------------------------------------------------------------------------
// sa_matmul_engine
// Output-stationary systolic engine computing C[DIMxDIM] = A[DIMxK] * B[KxDIM].
// Ports:
//   clk, rstn            clock, synchronous active-low reset (abandons any job)
//   start, k_len,        launch a job (IDLE only); K and operand signedness are
//   signed_en            latched at launch
//   in_valid/in_ready    one beat = column k of A (a_col) + row k of B (b_row)
//   a_col, b_row         A[i][k] at [i*DW +: DW], B[k][j] at [j*DW +: DW]
//   out_valid/out_ready  one result row per handshake, rows 0..DIM-1 in order
//   out_row, out_last    C[r][j] at [j*AW +: AW]; out_last marks row DIM-1
//   busy, done           busy outside IDLE; done pulses after the last row
// Input skew lines and the job FSM live here; the MAC cells are sa_pe.
// ----------------------------------------------------------------------------
module sa_matmul_engine
    import sa_pkg::*;
#(
    parameter  int DIM  = DIM_DEF,
    parameter  int DW   = DW_DEF,
    parameter  int AW   = AW_DEF,
    parameter  int KMAX = KMAX_DEF,
    localparam int KW   = kw_of(KMAX)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              signed_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIM*DW-1:0] a_col,
    input  logic [DIM*DW-1:0] b_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM*AW-1:0] out_row,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // The last beat needs 2*DIM-2 hops to reach the far corner PE, plus one edge to accumulate.
    localparam int FLUSH_LEN = 2 * DIM - 1;
    localparam int FW        = cw_of(FLUSH_LEN);
    localparam int RW        = cw_of(DIM);

    sa_state_e         state_r;
    logic [KW-1:0]     k_len_r;
    logic [KW-1:0]     beat_cnt_r;
    logic [FW-1:0]     flush_cnt_r;
    logic [RW-1:0]     row_cnt_r;
    logic              signed_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic              busy_r;
    logic              done_r;
    logic [DIM*AW-1:0] out_row_r;

    logic              fire_s;
    logic              clr_s;
    logic [RW-1:0]     row_idx_s;
    logic [DIM*AW-1:0] row_pick_s;
    logic              unused_edge_s;

    // Array interconnect: a_h_s runs left->right per row, b_v_s top->bottom per column.
    logic [DW:0]       a_h_s [DIM][DIM+1];
    logic [DW:0]       b_v_s [DIM+1][DIM];
    logic [AW-1:0]     acc_s [DIM][DIM];

    assign fire_s    = in_valid & in_ready_r;
    assign clr_s     = (state_r == ST_IDLE) & start;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_row   = out_row_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Skew lines: lane i is delayed i cycles; a cycle without an accepted beat enters as a bubble.
    for (genvar i = 0; i < DIM; i++) begin : g_skew
        logic [DW:0] a_word_s;
        logic [DW:0] b_word_s;

        assign a_word_s = {fire_s, {DW{fire_s}} & a_col[i*DW +: DW]};
        assign b_word_s = {fire_s, {DW{fire_s}} & b_row[i*DW +: DW]};

        if (i == 0) begin : g_direct
            assign a_h_s[i][0] = a_word_s;
            assign b_v_s[0][i] = b_word_s;
        end else begin : g_delay
            logic [DW:0] a_sh_r [i];
            logic [DW:0] b_sh_r [i];

            // Shift the tagged words one stage per cycle.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int k = 0; k < i; k++) begin
                        a_sh_r[k] <= '0;
                        b_sh_r[k] <= '0;
                    end
                end else begin
                    a_sh_r[0] <= a_word_s;
                    b_sh_r[0] <= b_word_s;
                    for (int k = 1; k < i; k++) begin
                        a_sh_r[k] <= a_sh_r[k-1];
                        b_sh_r[k] <= b_sh_r[k-1];
                    end
                end
            end

            assign a_h_s[i][0] = a_sh_r[i-1];
            assign b_v_s[0][i] = b_sh_r[i-1];
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            sa_pe #(
                .DW (DW),
                .AW (AW)
            ) u_pe (
                .clk       (clk),
                .rstn      (rstn),
                .clr       (clr_s),
                .signed_en (signed_r),
                .a_in      (a_h_s[i][j]),
                .b_in      (b_v_s[i][j]),
                .a_out     (a_h_s[i][j+1]),
                .b_out     (b_v_s[i+1][j]),
                .acc       (acc_s[i][j])
            );
        end
    end

    // Words leaving the right and bottom edges of the array are simply dropped.
    always_comb begin
        unused_edge_s = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            unused_edge_s = unused_edge_s ^ (^a_h_s[i][DIM]) ^ (^b_v_s[DIM][i]);
        end
    end

    // Row to load into the output register next: row 0 when leaving FLUSH, else the following row.
    always_comb begin
        row_pick_s = '0;
        if (state_r == ST_FLUSH) begin
            row_idx_s = '0;
        end else begin
            row_idx_s = row_cnt_r + RW'(1);
        end
        for (int j = 0; j < DIM; j++) begin
            row_pick_s[j*AW +: AW] = acc_s[row_idx_s][j];
        end
    end

    // Job FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            k_len_r     <= '0;
            beat_cnt_r  <= '0;
            flush_cnt_r <= '0;
            row_cnt_r   <= '0;
            signed_r    <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_row_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        k_len_r    <= k_len;
                        signed_r   <= signed_en;
                        beat_cnt_r <= '0;
                        busy_r     <= 1'b1;
                        if (k_len == KW'(0)) begin
                            // Empty product: accumulators are being cleared, drain zeros.
                            state_r     <= ST_DRAIN;
                            out_valid_r <= 1'b1;
                            out_last_r  <= (DIM == 1);
                            row_cnt_r   <= '0;
                            out_row_r   <= '0;
                        end else begin
                            state_r    <= ST_LOAD;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (fire_s) begin
                        beat_cnt_r <= beat_cnt_r + KW'(1);
                        if (beat_cnt_r == k_len_r - KW'(1)) begin
                            state_r     <= ST_FLUSH;
                            in_ready_r  <= 1'b0;
                            flush_cnt_r <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == FW'(FLUSH_LEN - 1)) begin
                        state_r     <= ST_DRAIN;
                        out_valid_r <= 1'b1;
                        out_last_r  <= (DIM == 1);
                        row_cnt_r   <= '0;
                        out_row_r   <= row_pick_s;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + FW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_last_r) begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            row_cnt_r   <= row_cnt_r + RW'(1);
                            out_last_r  <= (row_cnt_r == RW'(DIM - 2));
                            out_row_r   <= row_pick_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_matmul_engine.sv
// ----------------------------------------------------------------------------
// tb_sa_matmul_engine
// Randomised scoreboard bench: each job's expected C rows are computed from
// plain matrix arithmetic and queued; a monitor compares every presented row.
// ----------------------------------------------------------------------------
module tb_sa_matmul_engine;

    localparam int DIM  = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int KMAX = 16;
    localparam int KW   = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              signed_en;
    logic              in_valid;
    logic              in_ready;
    logic [DIM*DW-1:0] a_col;
    logic [DIM*DW-1:0] b_row;
    logic              out_valid;
    logic              out_ready;
    logic [DIM*AW-1:0] out_row;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct {
        logic [DIM*AW-1:0] row;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors      = 0;
    int   miscompares  = 0;
    int   stall_target = 0;

    always #5 clk = ~clk;

    sa_matmul_engine #(
        .DIM  (DIM),
        .DW   (DW),
        .AW   (AW),
        .KMAX (KMAX)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .k_len     (k_len),
        .signed_en (signed_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream: hold out_ready low stall_target cycles for each presented row.
    initial begin
        int wcnt;
        wcnt      = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (wcnt >= stall_target) begin
                    out_ready = 1'b1;
                    wcnt      = 0;
                end else begin
                    out_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                out_ready = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Monitor: compare every handshaken row; a stalled row must already equal the expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 128'(out_valid), 128'(0));
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("out_row", 128'(out_row), 128'(e.row));
                    check("out_last", 128'(out_last), 128'(e.last));
                end else begin
                    check("stall_row", 128'(out_row), 128'(exp_q[0].row));
                end
            end
        end
    end

    // mode: 0 random, 1 random with bubbles, 2 identity, 3 all 0x80, 4 all 0xFF
    task automatic run_job(input int k, input bit sgn, input int mode, input bit do_reset, input bit poke);
        logic [DW-1:0] am [DIM][KMAX];
        logic [DW-1:0] bm [KMAX][DIM];
        exp_t          e;
        longint        sum;
        longint        av;
        longint        bv;
        int            idx;
        int            cyc;
        int            load_cyc;
        int            wt;
        bit            acc_beat;

        for (int kk = 0; kk < KMAX; kk++) begin
            for (int i = 0; i < DIM; i++) begin
                case (mode)
                    2:       begin am[i][kk] = (i == kk) ? 8'd1 : 8'd0; bm[kk][i] = 8'(4 * kk + i); end
                    3:       begin am[i][kk] = 8'h80; bm[kk][i] = 8'h80; end
                    4:       begin am[i][kk] = 8'hFF; bm[kk][i] = 8'hFF; end
                    default: begin am[i][kk] = 8'($urandom); bm[kk][i] = 8'($urandom); end
                endcase
            end
        end

        if (!do_reset) begin
            for (int r = 0; r < DIM; r++) begin
                e.row  = '0;
                e.last = (r == DIM - 1);
                for (int j = 0; j < DIM; j++) begin
                    sum = 0;
                    for (int kk = 0; kk < k; kk++) begin
                        av  = sgn ? longint'($signed(am[r][kk])) : longint'(am[r][kk]);
                        bv  = sgn ? longint'($signed(bm[kk][j])) : longint'(bm[kk][j]);
                        sum = sum + av * bv;
                    end
                    e.row[j*AW +: AW] = sum[AW-1:0];
                end
                exp_q.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        start     = 1'b1;
        k_len     = KW'(k);
        signed_en = sgn;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        k_len     = KW'($urandom_range(0, KMAX));
        signed_en = 1'($urandom);

        if (k == 0) begin
            @(negedge clk);
            check("k0_direct_drain", 128'(out_valid), 128'(1));
        end
        if (poke) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            k_len = KW'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        idx      = 0;
        cyc      = 0;
        load_cyc = 0;
        while (idx < k && cyc < 200) begin
            in_valid = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
            for (int i = 0; i < DIM; i++) begin
                a_col[i*DW +: DW] = am[i][idx];
                b_row[i*DW +: DW] = bm[idx][i];
            end
            @(negedge clk);
            if (in_ready) load_cyc++;
            acc_beat = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc_beat) idx++;
            cyc++;
            if (do_reset && idx == 3) begin
                in_valid = 1'b0;
                rstn     = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_in_ready", 128'(in_ready), 128'(0));
                check("rst_out_valid", 128'(out_valid), 128'(0));
                return;
            end
        end
        in_valid = 1'b0;
        check("beats_accepted", 128'(idx), 128'(k));
        if (k > 0) begin
            @(negedge clk);
            check("in_ready_after_load", 128'(in_ready), 128'(0));
        end
        if (mode == 1) check("bubble_load_cycles", 128'(load_cyc), 128'(8));

        wt = 0;
        while (done !== 1'b1 && wt < 2000) begin
            @(negedge clk);
            wt++;
        end
        check("done_seen", 128'(done), 128'(1));
        check("busy_at_done", 128'(busy), 128'(0));
        check("rows_drained", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        check("done_pulse_width", 128'(done), 128'(0));
        if (poke) check("poke_ignored_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        signed_en = 1'b0;
        in_valid  = 1'b0;
        a_col     = '0;
        b_row     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(0));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_last", 128'(out_last), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        rstn = 1'b1;

        stall_target = 0;
        run_job(8, 1'b0, 0, 1'b1, 1'b0);   // abandoned by reset mid-LOAD
        run_job(8, 1'b0, 0, 1'b0, 1'b0);
        run_job(4, 1'b0, 2, 1'b0, 1'b0);   // identity
        run_job(16, 1'b1, 3, 1'b0, 1'b0);  // signed -128 * -128
        run_job(16, 1'b0, 4, 1'b0, 1'b0);  // unsigned 0xFF * 0xFF
        run_job(4, 1'b0, 1, 1'b0, 1'b0);   // bubbles
        stall_target = 5;
        run_job(6, 1'b1, 0, 1'b0, 1'b0);   // backpressure
        run_job(0, 1'b0, 0, 1'b0, 1'b1);   // empty product + start while busy
        for (int n = 0; n < 8; n++) begin
            stall_target = $urandom_range(0, 2);
            run_job($urandom_range(1, KMAX), 1'($urandom), 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
